// File: rtl/mem_write_stage_if.sv
// Signal bundle for mem_write_stage: execute-side request and data-memory write port.
interface mem_write_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned QWIDTH = 64,
  parameter int unsigned AWIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_src;
  logic [1:0]        in_size;
  logic [AWIDTH-1:0] in_addr;
  logic [XLEN-1:0]   rs2_data;
  logic [QWIDTH-1:0] xs2_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [AWIDTH-1:0] mem_addr;
  logic [XLEN-1:0]   mem_data;
  logic [3:0]        mem_strb;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              busy;

  // The write stage itself
  modport master (
    input  in_valid, in_src, in_size, in_addr, rs2_data, xs2_data, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_data, mem_strb, err_valid, err_code, busy
  );

  // Execute stage and memory environment
  modport slave (
    output in_valid, in_src, in_size, in_addr, rs2_data, xs2_data, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_data, mem_strb, err_valid, err_code, busy
  );
endinterface

// File: rtl/mem_write_stage.sv
// Buffered store path: source select, Q-format to fp32 conversion, lane alignment and write FIFO.
// Define MEM_WRITE_STAGE_ROUND_EN for round-to-nearest-even conversion (default truncates).
module mem_write_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned QWIDTH = 64,
  parameter int unsigned QFRAC  = 15,
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DEPTH  = 4
) (
  input logic              clk,
  input logic              reset,
  mem_write_stage_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned MW = QWIDTH + 1;
  localparam int unsigned LW = $clog2(MW);
  localparam logic [7:0]  EBIAS = 8'(127 - QFRAC);

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [XLEN-1:0]   data;
    logic [3:0]        strb;
  } wr_t;

  // S1 input side: magnitude and leading-one index of the XMM operand
  logic [MW-1:0] xs2_ext, in_mag;
  logic [LW-1:0] in_lead;
  always_comb begin
    xs2_ext = {bus.xs2_data[QWIDTH-1], bus.xs2_data};
    in_mag  = xs2_ext[MW-1] ? (MW'(0) - xs2_ext) : xs2_ext;
    in_lead = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (in_mag[i]) in_lead = LW'(i);
    end
  end

  logic              s1_valid, s1_sign;
  logic [1:0]        s1_src, s1_size;
  logic [AWIDTH-1:0] s1_addr;
  logic [XLEN-1:0]   s1_rs2;
  logic [MW-1:0]     s1_mag;
  logic [LW-1:0]     s1_lead;

  // S2: normalise, pack fp32, check, align
  logic [MW-1:0]   norm;
  logic [22:0]     mant;
  logic [7:0]      expo;
  logic [XLEN-1:0] fp, sel;
  logic            s2_err, enq;
  logic [1:0]      s2_code;
  wr_t             s2_wr;
`ifdef MEM_WRITE_STAGE_ROUND_EN
  logic            guard, sticky;
  logic [23:0]     mant_rnd;
`endif
  always_comb begin
    norm = s1_mag << (LW'(QWIDTH) - s1_lead);
    mant = 23'(norm >> (QWIDTH - 23));
    expo = 8'(s1_lead) + EBIAS;
`ifdef MEM_WRITE_STAGE_ROUND_EN
    guard    = norm[QWIDTH-24];
    sticky   = |norm[QWIDTH-25:0];
    mant_rnd = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
    mant     = mant_rnd[22:0];
    if (mant_rnd[23]) expo = expo + 8'd1;
`endif
    fp  = (s1_mag == '0) ? '0 : {s1_sign, expo, mant};
    sel = (s1_src == 2'b10) ? fp : s1_rs2;

    s2_err  = 1'b1;
    s2_code = 2'b00;
    if (s1_src != 2'b01 && s1_src != 2'b10)                   s2_code = 2'b01;
    else if (s1_size == 2'b11)                                s2_code = 2'b10;
    else if ((s1_size == 2'b01 && s1_addr[0]) ||
             (s1_size == 2'b10 && s1_addr[1:0] != 2'b00))     s2_code = 2'b11;
    else                                                      s2_err  = 1'b0;

    s2_wr.addr = {s1_addr[AWIDTH-1:2], 2'b00};
    case (s1_size)
      2'b00: begin
        s2_wr.data = XLEN'(sel[7:0]) << {s1_addr[1:0], 3'b000};
        s2_wr.strb = 4'b0001 << s1_addr[1:0];
      end
      2'b01: begin
        s2_wr.data = XLEN'(sel[15:0]) << {s1_addr[1], 4'b0000};
        s2_wr.strb = s1_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        s2_wr.data = sel;
        s2_wr.strb = 4'b1111;
      end
    endcase
    enq = s1_valid & ~s2_err;
  end

  // FIFO bookkeeping and next head of the memory port
  wr_t         fifo [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count_n;
  logic [PW+1:0] total_n;
  logic        accept, deq;
  wr_t         head_n;
  always_comb begin
    accept   = bus.in_valid & bus.in_ready;
    deq      = bus.mem_valid & bus.mem_ready;
    wr_ptr_n = wr_ptr + (PW+1)'(enq);
    rd_ptr_n = rd_ptr + (PW+1)'(deq);
    count_n  = wr_ptr_n - rd_ptr_n;
    total_n  = (PW+2)'(count_n) + (PW+2)'(accept);
    if (count_n == '0)                    head_n = '0;
    else if (enq && wr_ptr == rd_ptr_n)   head_n = s2_wr;
    else                                  head_n = fifo[rd_ptr_n[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_data  <= '0;
      bus.mem_strb  <= '0;
      bus.err_valid <= 1'b0;
      bus.err_code  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_src  <= bus.in_src;
        s1_size <= bus.in_size;
        s1_addr <= bus.in_addr;
        s1_rs2  <= bus.rs2_data;
        s1_sign <= bus.xs2_data[QWIDTH-1];
        s1_mag  <= in_mag;
        s1_lead <= in_lead;
      end
      if (enq) fifo[wr_ptr[PW-1:0]] <= s2_wr;
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      bus.in_ready  <= total_n < (PW+2)'(DEPTH);
      bus.mem_valid <= count_n != '0;
      bus.mem_addr  <= head_n.addr;
      bus.mem_data  <= head_n.data;
      bus.mem_strb  <= head_n.strb;
      bus.err_valid <= s1_valid & s2_err;
      bus.err_code  <= (s1_valid & s2_err) ? s2_code : 2'b00;
      bus.busy      <= accept | (count_n != '0);
    end
  end
endmodule
